// File: rtl/multi_sync_debounce.sv
// Multi-channel synchroniser and debouncer: per-channel flop chain, per-channel
// debounce counter paced by a shared prescaler tick, registered rise/fall strobes.
module multi_sync_debounce #(
    parameter int               WIDTH        = 4,
    parameter int               SYNC_STAGES  = 2,
    parameter int               DEBOUNCE_CNT = 50,
    parameter int               TICK_DIV     = 1,
    parameter logic [WIDTH-1:0] RST_VAL      = '0
) (
    input  logic             dest_clk_i,
    input  logic             dest_rst_i,
    input  logic [WIDTH-1:0] raw_sig_i,
    output logic [WIDTH-1:0] sync_sig_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             busy_o
);

    localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;
    logic             busy_next;

    // Plain flop chain, no logic between stages, so metastability can settle.
    always_ff @(posedge dest_clk_i or posedge dest_rst_i) begin
        if (dest_rst_i) begin
            for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= RST_VAL;
        end else begin
            sync_q[0] <= raw_sig_i;
            for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge dest_clk_i or posedge dest_rst_i) begin
        if (dest_rst_i) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_MAX) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // With TICK_DIV=1 the counter is pinned at 0 == PRE_MAX, so tick is always high.
    assign tick = (pre_cnt == PRE_MAX);

    // Agreement clears the count even off-tick, which is what rejects short glitches.
    always_comb begin
        busy_next = 1'b0;
        d_next    = sync_sig_o;
        rise_next = '0;
        fall_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = cnt[i];
            if (s[i] == sync_sig_o[i]) begin
                cnt_next[i] = '0;
            end else if (tick && (cnt[i] == CNT_MAX)) begin
                cnt_next[i]  = '0;
                d_next[i]    = s[i];
                rise_next[i] = s[i];
                fall_next[i] = ~s[i];
            end else if (tick) begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
            busy_next = busy_next | (cnt_next[i] != '0);
        end
    end

    always_ff @(posedge dest_clk_i or posedge dest_rst_i) begin
        if (dest_rst_i) begin
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
            sync_sig_o <= RST_VAL;
            rise_o     <= '0;
            fall_o     <= '0;
            busy_o     <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
            sync_sig_o <= d_next;
            rise_o     <= rise_next;
            fall_o     <= fall_next;
            busy_o     <= busy_next;
        end
    end

endmodule

// File: doc/multi_sync_debounce.md
# multi_sync_debounce

Multi-channel successor to the single-bit synchroniser/debouncer. It brings `WIDTH` asynchronous raw inputs (buttons, switches, UART control lines) into the `dest_clk_i` domain through a configurable-depth flop chain. Each channel is debounced by its own counter, paced by a shared tick prescaler. Per-channel rise/fall strobes and a busy flag are provided for the control logic downstream.

## Interface
- `WIDTH`, 4: number of independent channels, at least 1.
- `SYNC_STAGES`, 2: synchroniser flop depth per channel, at least 2.
- `DEBOUNCE_CNT`, 50: consecutive ticks of disagreement needed to commit a new level, at least 1.
- `TICK_DIV`, 1: prescaler divide ratio, at least 1; 1 means a tick every clock.
- `RST_VAL`, '0: `WIDTH`-bit reset level of the synchroniser flops and the debounced outputs.

Ports:
- `dest_clk_i`  in  1  destination clock; the block's only clock.
- `dest_rst_i`  in  1  asynchronous, active-high reset.
- `raw_sig_i`  in  WIDTH  asynchronous raw inputs.
- `sync_sig_o`  out  WIDTH  debounced, synchronised levels.
- `rise_o`  out  WIDTH  one-cycle strobe when a channel commits 0→1.
- `fall_o`  out  WIDTH  one-cycle strobe when a channel commits 1→0.
- `busy_o`  out  1  high while any channel counter is non-zero.

## Operation
- **Synchroniser.** Per channel, a `SYNC_STAGES`-deep flop chain with no logic between stages. Its last stage is `s[i]`.
- **Prescaler.** One shared counter of width `$clog2(TICK_DIV)`, minimum 1. It counts 0 to `TICK_DIV-1` and wraps. `tick` is high when the count is `TICK_DIV-1`. If `TICK_DIV=1`, `tick` is constantly 1.
- **Per-channel counter.** `cnt[i]` has width `$clog2(DEBOUNCE_CNT)`, minimum 1. Channel state is `d[i]`, which drives `sync_sig_o[i]`. Priority per edge:
  - If `s[i]==d[i]`: clear `cnt[i]` to 0, whether or not `tick` is high. This rejects glitches.
  - Else if `tick` and `cnt[i]==DEBOUNCE_CNT-1`: set `d[i]<=s[i]` and `cnt[i]<=0`. Set `rise_o[i]<=s[i]` and `fall_o[i]<=~s[i]`.
  - Else if `tick`: `cnt[i]<=cnt[i]+1`.
  - Otherwise hold.
- **Strobes.** `rise_o` and `fall_o` are registered. They are high for exactly the one cycle in which the new `sync_sig_o` value first appears; otherwise 0. `rise_o[i]` and `fall_o[i]` are never both high.
- **Channel independence.** Channels are fully independent apart from the shared `tick`. Any number of channels may commit on the same edge.
- **Busy flag.** `busy_o` is the registered OR of `(cnt[i]!=0)`.
- **Counter bounds.** The counter never exceeds `DEBOUNCE_CNT-1`, so no wrap-around is possible.

## Timing
- **Reset.** Asserting `dest_rst_i` takes effect immediately, independent of the clock:
  - synchroniser flops ← `RST_VAL`
  - `sync_sig_o` ← `RST_VAL`
  - `rise_o`, `fall_o` ← 0
  - `busy_o` ← 0
  - all counters and the prescaler ← 0
- **Reset mid-operation.** A pending count is discarded and no strobe is produced. After release, a raw level equal to `RST_VAL` produces no edge.
- **Latency, `TICK_DIV=1`.** Let edge k be the first edge where synchroniser stage 1 captures a new stable level. `sync_sig_o` and the strobe change at edge `k+SYNC_STAGES+DEBOUNCE_CNT-1`. The output is valid in the following cycle.
  - Example: `SYNC_STAGES=2`, `DEBOUNCE_CNT=4` gives a change at edge k+5.
  - `DEBOUNCE_CNT=1` gives a plain synchroniser with strobes, changing at edge `k+SYNC_STAGES`.
- **Latency, `TICK_DIV>1`.** The commit occurs between `(DEBOUNCE_CNT-1)*TICK_DIV+1` and `DEBOUNCE_CNT*TICK_DIV` cycles after `s[i]` first differs. The commit edge always coincides with `tick`.
- **Glitch rejection.** An `s[i]` pulse lasting at most `DEBOUNCE_CNT-1` ticks never reaches `sync_sig_o` (with `TICK_DIV=1`, ticks equal cycles).
- **Boundary case.** If `s[i]` returns to `d[i]` on the very edge where `cnt==DEBOUNCE_CNT-1`, the `s==d` rule wins: no commit, counter cleared.

## Test plan
- **Basic commit.** `WIDTH=4`, `SYNC_STAGES=2`, `DEBOUNCE_CNT=4`, `TICK_DIV=1`, `RST_VAL=0`. Step `raw[0]` 0→1 before edge k → `sync_sig_o[0]` rises at edge k+5. `rise_o[0]` is high for exactly one cycle. Other bits stay 0. `busy_o` is high from edge k+2 to k+4.
- **Glitch rejection.** Same configuration. Drive a 3-cycle high pulse on `raw[1]` → `sync_sig_o[1]`, `rise_o` and `fall_o` stay 0; `cnt` returns to 0. A 4-cycle pulse → `rise_o[1]` fires, and later `fall_o[1]` fires.
- **Simultaneous channels.** Same configuration. Rise `raw[3:0]=4'hF` on the same edge → all four `rise_o` bits strobe on the same cycle; `sync_sig_o=4'hF`. Then drop only `raw[2]` → only `fall_o[2]` fires.
- **Prescaler.** `TICK_DIV=10`, `DEBOUNCE_CNT=3`. Hold a new level → the commit lands on a tick edge, 21 to 30 cycles after `s` changes. A 20-cycle pulse never commits.
- **Reset value and mid-count reset.**
  - `RST_VAL=4'b1010`, `raw=4'b1010` during and after reset → no strobes and `sync_sig_o=4'b1010` throughout.
  - Assert `dest_rst_i` asynchronously while `cnt[0]=2` → outputs return to `RST_VAL` immediately. No strobe is produced, and `busy_o` is 0 immediately.
